// File: rtl/mskaes_rcon_sched_pkg.sv
// Shared AES constants for the masked key-schedule round-constant sequencer:
// key-size encodings, per-size step counts, rcon seeds and GF(2^8) helpers.
package mskaes_rcon_sched_pkg;

  localparam logic [1:0] KS_128  = 2'b00;
  localparam logic [1:0] KS_192  = 2'b01;
  localparam logic [1:0] KS_256  = 2'b10;
  localparam logic [1:0] KS_RSVD = 2'b11;

  // Number of expansion steps per key size
  localparam logic [3:0] NSTEP_128 = 4'd10;
  localparam logic [3:0] NSTEP_192 = 4'd8;
  localparam logic [3:0] NSTEP_256 = 4'd13;

  // rcon seeds: forward always starts at 0x01, inverse starts at the
  // last rcon the forward schedule would have used for that key size
  localparam logic [7:0] RCON_FWD_INIT = 8'h01;
  localparam logic [7:0] RCON_INV_128  = 8'h36;
  localparam logic [7:0] RCON_INV_192  = 8'h80;
  localparam logic [7:0] RCON_INV_256  = 8'h40;

  // Reduction constants for multiply / divide by x in GF(2^8)
  localparam logic [7:0] XTIME_POLY     = 8'h1b;
  localparam logic [7:0] INV_XTIME_POLY = 8'h8d;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rcon_state_e;

  // Index of the final step for a key size; reserved encoding behaves as AES-128
  function automatic logic [3:0] last_step_idx(input logic [1:0] ks);
    logic [3:0] n;
    case (ks)
      KS_192:  n = NSTEP_192;
      KS_256:  n = NSTEP_256;
      default: n = NSTEP_128;
    endcase
    return n - 4'd1;
  endfunction

  // First rcon of a sequence
  function automatic logic [7:0] rcon_init(input logic [1:0] ks, input logic inv);
    logic [7:0] v;
    if (!inv) begin
      v = RCON_FWD_INIT;
    end else begin
      case (ks)
        KS_192:  v = RCON_INV_192;
        KS_256:  v = RCON_INV_256;
        default: v = RCON_INV_128;
      endcase
    end
    return v;
  endfunction

  // Multiply by x
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? XTIME_POLY : 8'h00);
  endfunction

  // Divide by x (inverse of xtime)
  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    return {1'b0, a[7:1]} ^ (a[0] ? INV_XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mskaes_rcon_sched_cst.sv
// MSKcst: turns a public constant into a non-random d-share sharing.
// Share 0 carries the value, all remaining shares are zero.
module mskaes_rcon_sched_cst #(
  parameter int d     = 2,
  parameter int count = 8
) (
  input  logic [count-1:0]   i_x,
  output logic [count*d-1:0] o_sh
);

  assign o_sh[count-1:0] = i_x;

  generate
    if (d > 1) begin : g_zero_shares
      assign o_sh[count*d-1:count] = '0;
    end
  endgenerate

endmodule

// File: rtl/mskaes_rcon_sched.sv
// Round-constant sequencer for a masked AES key expansion. Walks the rcon
// sequence forward (encryption) or backward (decryption) one expansion step
// per 'step' pulse and tells the key-schedule datapath what each step does.
//
// Handshake: 'start' is taken only when busy=0; 'step' is taken only when
// busy=1 and consumes the step currently described by the outputs; the
// cycle after the step with last=1 is consumed, done pulses for one cycle.
module mskaes_rcon_sched
  import mskaes_rcon_sched_pkg::*;
#(
  parameter int d      = 2,
  parameter int INV_EN = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     key_size,
  input  logic           inverse,
  input  logic           step,
  input  logic           mask_rcon,
  output logic [8*d-1:0] sh_rcon,
  output logic           rcon_step,
  output logic           sub_only,
  output logic           last,
  output logic           busy,
  output logic           done
);

  localparam bit INV_ON = (INV_EN != 0);

  rcon_state_e r_state;
  logic [3:0]  r_step_cnt;
  logic [7:0]  r_rcon;
  logic [1:0]  r_key_size;
  logic        r_inverse;
  logic        r_done;

  logic        w_busy;
  logic        w_is256;
  logic        w_rcon_step;
  logic        w_sub_only;
  logic        w_last;
  logic        w_inv_in;
  logic [7:0]  w_rcon_gated;

  assign w_inv_in    = INV_ON & inverse;
  assign w_busy      = (r_state == ST_RUN);
  assign w_is256     = (r_key_size == KS_256);
  // AES-256 alternates rcon steps (even index) with SubWord-only steps (odd)
  assign w_rcon_step = w_busy & (~w_is256 | ~r_step_cnt[0]);
  assign w_sub_only  = w_busy & w_is256 & r_step_cnt[0];
  assign w_last      = w_busy & (r_step_cnt == last_step_idx(r_key_size));
  assign w_rcon_gated = r_rcon & {8{w_busy & w_rcon_step & mask_rcon}};

  // FSM, step counter and rcon register; done is a registered pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_step_cnt <= 4'd0;
      r_rcon     <= RCON_FWD_INIT;
      r_key_size <= KS_128;
      r_inverse  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_RUN;
            r_key_size <= key_size;
            r_inverse  <= w_inv_in;
            r_step_cnt <= 4'd0;
            r_rcon     <= rcon_init(key_size, w_inv_in);
          end
        end
        ST_RUN: begin
          if (step) begin
            if (w_rcon_step) begin
              r_rcon <= r_inverse ? inv_xtime(r_rcon) : xtime(r_rcon);
            end
            if (w_last) begin
              r_state    <= ST_IDLE;
              r_step_cnt <= 4'd0;
              r_done     <= 1'b1;
            end else begin
              r_step_cnt <= r_step_cnt + 4'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  mskaes_rcon_sched_cst #(
    .d     (d),
    .count (8)
  ) u_cst (
    .i_x  (w_rcon_gated),
    .o_sh (sh_rcon)
  );

  assign rcon_step = w_rcon_step;
  assign sub_only  = w_sub_only;
  assign last      = w_last;
  assign busy      = w_busy;
  assign done      = r_done;

endmodule
